// File: rtl/cla2_pkg.sv
// rtl/cla2_pkg.sv - shared width, propagate/generate bundle and lookahead carry helper for cla2
package cla2_pkg;

    localparam int width = 2;

    // Per-bit propagate and generate terms, bit 0 is the LSB.
    typedef struct packed {
        logic [width-1:0] p;
        logic [width-1:0] g;
    } pg_t;

    // Returns {c2, c1}. Each carry is formed directly from p/g/ci,
    // so c2 does not wait on c1.
    function automatic logic [1:0] lookahead(input pg_t pg, input logic ci);
        logic c1;
        logic c2;
        c1 = pg.g[0] | (pg.p[0] & ci);
        c2 = pg.g[1] | (pg.p[1] & pg.g[0]) | (pg.p[1] & pg.p[0] & ci);
        return {c2, c1};
    endfunction

endpackage

// File: rtl/cla2_xorgate.sv
// rtl/cla2_xorgate.sv - 2-input XOR used for the propagate and sum terms
// Ports: a, b - inputs; y - a XOR b.
module xorgate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/cla2.sv
// rtl/cla2.sv - 2-bit registered carry-lookahead adder
// Ports: clk, rst (async, active-high); a, b - 2-bit operands; ci - carry-in;
//        s - registered sum; carry1 - registered carry into bit 1;
//        carry2 - registered final carry-out. Latency 1, throughput 1/cycle.
module cla2
    import cla2_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             ci,
    output logic [width-1:0] s,
    output logic             carry1,
    output logic             carry2
);

    logic [width-1:0] p;
    logic [width-1:0] sum_d;
    logic [1:0]       c;      // {c2, c1}
    pg_t              pg;

    xorgate u_p0 (.a(a[0]), .b(b[0]), .y(p[0]));
    xorgate u_p1 (.a(a[1]), .b(b[1]), .y(p[1]));

    assign pg = '{p: p, g: a & b};
    assign c  = lookahead(pg, ci);

    xorgate u_s0 (.a(p[0]), .b(ci),   .y(sum_d[0]));
    xorgate u_s1 (.a(p[1]), .b(c[0]), .y(sum_d[1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s      <= '0;
            carry1 <= 1'b0;
            carry2 <= 1'b0;
        end else begin
            s      <= sum_d;
            carry1 <= c[0];
            carry2 <= c[1];
        end
    end

endmodule

// File: tb/tb_cla2.sv
// tb/tb_cla2.sv - self-checking bench for cla2
module tb_cla2;

    logic       clk;
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic       ci;
    logic [1:0] s;
    logic       carry1;
    logic       carry2;

    int tests;
    int fails;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       ci;
        logic [1:0] s;
        logic       c1;
        logic       c2;
    } vec_t;

    vec_t vecs [6];

    cla2 dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .s      (s),
        .carry1 (carry1),
        .carry2 (carry2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {carry2, carry1, s} against the expected value.
    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {carry2, carry1, s};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got c2=%b c1=%b s=%b, expected c2=%b c1=%b s=%b",
                     name, got[3], got[2], got[1:0], exp[3], exp[2], exp[1:0]);
        end
    endtask

    // Drive away from the edge, then sample just after the next rising edge.
    task automatic apply(input logic [1:0] ta, input logic [1:0] tb, input logic tci);
        @(negedge clk);
        a  = ta;
        b  = tb;
        ci = tci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp;
        logic [2:0] total;
        logic       c1;

        tests = 0;
        fails = 0;

        vecs[0] = '{a: 2'b00, b: 2'b00, ci: 1'b0, s: 2'b00, c1: 1'b0, c2: 1'b0};
        vecs[1] = '{a: 2'b00, b: 2'b10, ci: 1'b1, s: 2'b11, c1: 1'b0, c2: 1'b0};
        vecs[2] = '{a: 2'b01, b: 2'b01, ci: 1'b0, s: 2'b10, c1: 1'b1, c2: 1'b0};
        vecs[3] = '{a: 2'b11, b: 2'b11, ci: 1'b0, s: 2'b10, c1: 1'b1, c2: 1'b1};
        vecs[4] = '{a: 2'b11, b: 2'b11, ci: 1'b1, s: 2'b11, c1: 1'b1, c2: 1'b1};
        vecs[5] = '{a: 2'b10, b: 2'b01, ci: 1'b1, s: 2'b00, c1: 1'b1, c2: 1'b1};

        rst = 1'b1;
        a   = 2'b11;
        b   = 2'b11;
        ci  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'b0000);

        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].ci);
            check($sformatf("vec%0d", i), {vecs[i].c2, vecs[i].c1, vecs[i].s});
        end

        // Exhaustive sweep against an arithmetic model.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = i[4:0];
            apply(v[4:3], v[2:1], v[0]);
            total = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b00, v[0]};
            c1    = ({1'b0, v[3]} + {1'b0, v[1]} + {1'b0, v[0]}) > 2'd1;
            exp   = {total[2], c1, total[1:0]};
            check($sformatf("exh_a%b_b%b_ci%b", v[4:3], v[2:1], v[0]), exp);
        end

        // Inputs changing between edges must not reach the outputs.
        apply(2'b01, 2'b10, 1'b0);
        check("hold_before", 4'b0011);
        a  = 2'b11;
        b  = 2'b11;
        ci = 1'b1;
        #2;
        check("hold_mid_cycle", 4'b0011);
        @(posedge clk);
        #1;
        check("hold_next_edge", 4'b1111);

        // Asynchronous reset mid-cycle with nonzero outputs.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_immediate", 4'b0000);
        @(posedge clk);
        #1;
        check("rst_held_edge", 4'b0000);
        @(negedge clk);
        a   = 2'b01;
        b   = 2'b10;
        ci  = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_released_pre_edge", 4'b0000);
        @(posedge clk);
        #1;
        check("rst_first_edge", 4'b0011);
        apply(2'b10, 2'b10, 1'b1);
        check("rst_second_edge", 4'b1001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
